// File: rtl/rp8_bd_arb.sv
// rtl/rp8_bd_arb.sv - two-port data RAM arbiter for the rp8 core and a secondary master
//
// Port 0 (core) has fixed priority. Port 1 (DMA/debug) is guaranteed progress by a
// starvation counter: after STV consecutive denials it wins the next cycle.
// Optional build macro RP8_BD_ARB_RR_EN swaps the starvation counter for plain
// round-robin arbitration between the two ports (STV then has no effect).
// Read data comes back one cycle after the grant, steered to the issuing port.

module rp8_bd_arb #(
  parameter int DAW = 13,
  parameter int IDW = 6,
  parameter int STV = 4
) (
  input  logic           clk,
  input  logic           rst,

  input  logic           p0_req,
  input  logic           p0_wen,
  input  logic [DAW-1:0] p0_adr,
  input  logic [IDW-1:0] p0_wid,
  input  logic [7:0]     p0_wdt,
  output logic           p0_ack,
  output logic [7:0]     p0_rdt,
  output logic [IDW-1:0] p0_rid,
  output logic           p0_ren,

  input  logic           p1_req,
  input  logic           p1_wen,
  input  logic [DAW-1:0] p1_adr,
  input  logic [IDW-1:0] p1_wid,
  input  logic [7:0]     p1_wdt,
  output logic           p1_ack,
  output logic [7:0]     p1_rdt,
  output logic [IDW-1:0] p1_rid,
  output logic           p1_ren,

  output logic           mem_ena,
  output logic           mem_wen,
  output logic [DAW-1:0] mem_adr,
  output logic [7:0]     mem_wdt,
  input  logic [7:0]     mem_rdt
);

  logic w_sel0;
  logic w_sel1;

`ifdef RP8_BD_ARB_RR_EN
  // 1 = port 1 won the most recent grant, so port 0 is favoured next.
  logic r_last;

  // Round-robin grant: on contention the port that did not win last goes first.
  always_comb begin
    w_sel1 = p1_req & (~p0_req | ~r_last);
    w_sel0 = p0_req & ~w_sel1;
  end

  // Remember the winner of every granted cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_sel0 | w_sel1) begin
      r_last <= w_sel1;
    end
  end
`else
  localparam logic [7:0] STV_C = 8'(STV);

  // Consecutive cycles port 1 has been requesting but denied.
  logic [7:0] r_stv_cnt;

  // Fixed priority grant with port 1 forced once it has waited STV cycles.
  always_comb begin
    w_sel1 = p1_req & ((r_stv_cnt == STV_C) | ~p0_req);
    w_sel0 = p0_req & ~w_sel1;
  end

  // Count port-1 denials, saturating; any port-1 grant or idle port 1 clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stv_cnt <= 8'd0;
    end else if (~p1_req | w_sel1) begin
      r_stv_cnt <= 8'd0;
    end else if (r_stv_cnt != STV_C) begin
      r_stv_cnt <= r_stv_cnt + 8'd1;
    end
  end
`endif

  assign p0_ack  = w_sel0;
  assign p1_ack  = w_sel1;
  assign mem_ena = p0_req | p1_req;

  // RAM request mux; idle drives a harmless zero command.
  always_comb begin
    mem_wen = 1'b0;
    mem_adr = '0;
    mem_wdt = 8'd0;
    if (w_sel0) begin
      mem_wen = p0_wen;
      mem_adr = p0_adr;
      mem_wdt = p0_wdt;
    end else if (w_sel1) begin
      mem_wen = p1_wen;
      mem_adr = p1_adr;
      mem_wdt = p1_wdt;
    end
  end

  logic           r_p0_ren;
  logic           r_p1_ren;
  logic [IDW-1:0] r_p0_rid;
  logic [IDW-1:0] r_p1_rid;

  // Track granted reads so the RAM data next cycle is tagged and steered to the issuer.
  // The rid registers only change on a new read from their port, so they hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_ren <= 1'b0;
      r_p1_ren <= 1'b0;
      r_p0_rid <= '0;
      r_p1_rid <= '0;
    end else begin
      r_p0_ren <= w_sel0 & ~p0_wen;
      r_p1_ren <= w_sel1 & ~p1_wen;
      if (w_sel0 & ~p0_wen) begin
        r_p0_rid <= p0_wid;
      end
      if (w_sel1 & ~p1_wen) begin
        r_p1_rid <= p1_wid;
      end
    end
  end

  assign p0_ren = r_p0_ren;
  assign p1_ren = r_p1_ren;
  assign p0_rid = r_p0_rid;
  assign p1_rid = r_p1_rid;
  assign p0_rdt = mem_rdt;
  assign p1_rdt = mem_rdt;

endmodule

// File: tb/tb_rp8_bd_arb.sv
// tb/tb_rp8_bd_arb.sv - randomized self-checking bench for rp8_bd_arb

module tb_rp8_bd_arb;

  localparam int DAW = 13;
  localparam int IDW = 6;
  localparam int STV = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           p0_req = 0, p0_wen = 0, p1_req = 0, p1_wen = 0;
  logic [DAW-1:0] p0_adr = '0, p1_adr = '0;
  logic [IDW-1:0] p0_wid = '0, p1_wid = '0;
  logic [7:0]     p0_wdt = '0, p1_wdt = '0;
  logic           p0_ack, p1_ack, p0_ren, p1_ren;
  logic [7:0]     p0_rdt, p1_rdt;
  logic [IDW-1:0] p0_rid, p1_rid;
  logic           mem_ena, mem_wen;
  logic [DAW-1:0] mem_adr;
  logic [7:0]     mem_wdt;
  logic [7:0]     mem_rdt;

  rp8_bd_arb #(.DAW(DAW), .IDW(IDW), .STV(STV)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_wen(p0_wen), .p0_adr(p0_adr), .p0_wid(p0_wid), .p0_wdt(p0_wdt),
    .p0_ack(p0_ack), .p0_rdt(p0_rdt), .p0_rid(p0_rid), .p0_ren(p0_ren),
    .p1_req(p1_req), .p1_wen(p1_wen), .p1_adr(p1_adr), .p1_wid(p1_wid), .p1_wdt(p1_wdt),
    .p1_ack(p1_ack), .p1_rdt(p1_rdt), .p1_rid(p1_rid), .p1_ren(p1_ren),
    .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_adr(mem_adr), .mem_wdt(mem_wdt),
    .mem_rdt(mem_rdt)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with one cycle read latency.
  logic [7:0] ram [0:(1<<DAW)-1];
  always @(posedge clk) begin
    if (mem_ena) begin
      if (mem_wen) ram[mem_adr] <= mem_wdt;
      else         mem_rdt <= ram[mem_adr];
    end
  end

  // Reference model state: expected memory image, denial count, pending returns.
  logic [7:0]     mm [0:(1<<DAW)-1];
  int             den;
  logic           x_ren0, x_ren1;
  logic [7:0]     x_rdt0, x_rdt1;
  logic [IDW-1:0] x_rid0, x_rid1;

  // Observations of the last step, used by directed checks.
  logic           g0, g1, o_ren0, o_ren1;
  logic [7:0]     o_rdt0, o_rdt1;
  logic [IDW-1:0] o_rid0, o_rid1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs mid-cycle against the model, then advance the model.
  task automatic step(input logic do_rst);
    logic e0, e1;
    logic n0, n1;
    rst = do_rst;
    @(negedge clk);
    e1 = p1_req && ((den == STV) || !p0_req);
    e0 = p0_req && !e1;
    check("p0_ack", 32'(p0_ack), 32'(e0));
    check("p1_ack", 32'(p1_ack), 32'(e1));
    check("mem_ena", 32'(mem_ena), 32'(p0_req | p1_req));
    if (e0 || e1) begin
      check("mem_wen", 32'(mem_wen), 32'(e0 ? p0_wen : p1_wen));
      check("mem_adr", 32'(mem_adr), 32'(e0 ? p0_adr : p1_adr));
      if (mem_wen) check("mem_wdt", 32'(mem_wdt), 32'(e0 ? p0_wdt : p1_wdt));
    end else begin
      check("idle_wen", 32'(mem_wen), 32'd0);
    end
    check("p0_ren", 32'(p0_ren), 32'(x_ren0));
    check("p1_ren", 32'(p1_ren), 32'(x_ren1));
    check("p0_rid", 32'(p0_rid), 32'(x_rid0));
    check("p1_rid", 32'(p1_rid), 32'(x_rid1));
    if (x_ren0) check("p0_rdt", 32'(p0_rdt), 32'(x_rdt0));
    if (x_ren1) check("p1_rdt", 32'(p1_rdt), 32'(x_rdt1));
    g0 = e0; g1 = e1;
    o_ren0 = p0_ren; o_ren1 = p1_ren;
    o_rdt0 = p0_rdt; o_rdt1 = p1_rdt;
    o_rid0 = p0_rid; o_rid1 = p1_rid;

    n0 = 1'b0; n1 = 1'b0;
    if (e0) begin
      if (p0_wen) mm[p0_adr] = p0_wdt;
      else begin n0 = 1'b1; x_rdt0 = mm[p0_adr]; x_rid0 = p0_wid; end
    end
    if (e1) begin
      if (p1_wen) mm[p1_adr] = p1_wdt;
      else begin n1 = 1'b1; x_rdt1 = mm[p1_adr]; x_rid1 = p1_wid; end
    end
    if (p1_req && !e1) den = (den + 1 > STV) ? STV : den + 1;
    else               den = 0;
    x_ren0 = n0; x_ren1 = n1;
    if (do_rst) begin
      x_ren0 = 1'b0; x_ren1 = 1'b0;
      x_rid0 = '0;   x_rid1 = '0;
      den = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic req, input logic wen, input logic [DAW-1:0] adr,
                        input logic [IDW-1:0] wid, input logic [7:0] wdt);
    p0_req = req; p0_wen = wen; p0_adr = adr; p0_wid = wid; p0_wdt = wdt;
  endtask

  task automatic set_p1(input logic req, input logic wen, input logic [DAW-1:0] adr,
                        input logic [IDW-1:0] wid, input logic [7:0] wdt);
    p1_req = req; p1_wen = wen; p1_adr = adr; p1_wid = wid; p1_wdt = wdt;
  endtask

  initial begin
    for (int i = 0; i < (1<<DAW); i++) begin
      ram[i] = 8'(i) ^ 8'h5A;
      mm[i]  = 8'(i) ^ 8'h5A;
    end
    den = 0;
    x_ren0 = 0; x_ren1 = 0; x_rid0 = '0; x_rid1 = '0; x_rdt0 = '0; x_rdt1 = '0;

    // Reset then idle.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1);
    step(1'b0);
    check("t1_ren0", 32'(o_ren0), 32'd0);
    check("t1_rid1", 32'(o_rid1), 32'd0);

    // Port 0 write then read back.
    set_p0(1, 1, 13'h0100, 6'h00, 8'hA5);
    step(1'b0);
    check("t2_wr_ack", 32'(g0), 32'd1);
    set_p0(1, 0, 13'h0100, 6'h2A, 8'h00);
    step(1'b0);
    check("t2_rd_ack", 32'(g0), 32'd1);
    set_p0(0, 0, '0, '0, '0);
    step(1'b0);
    check("t2_ren0", 32'(o_ren0), 32'd1);
    check("t2_rdt0", 32'(o_rdt0), 32'hA5);
    check("t2_rid0", 32'(o_rid0), 32'h2A);
    check("t2_ren1", 32'(o_ren1), 32'd0);

    // Starvation: both held, port 1 wins every (STV+1)th cycle.
    set_p0(1, 1, 13'h0200, '0, 8'h01);
    set_p1(1, 1, 13'h0201, '0, 8'h02);
    for (int k = 0; k < 3*(STV+1); k++) begin
      step(1'b0);
      check("t3_p1ack", 32'(g1), 32'(k % (STV+1) == STV));
      check("t3_p0ack", 32'(g0), 32'(k % (STV+1) != STV));
    end
    set_p0(0, 0, '0, '0, '0);
    set_p1(0, 0, '0, '0, '0);
    step(1'b0);

    // Alternating reads return in order with no bubble.
    ram[13'h0010] = 8'h11; mm[13'h0010] = 8'h11;
    ram[13'h0011] = 8'h22; mm[13'h0011] = 8'h22;
    set_p0(1, 0, 13'h0010, 6'd1, '0);
    step(1'b0);
    set_p0(0, 0, '0, '0, '0);
    set_p1(1, 0, 13'h0011, 6'd2, '0);
    step(1'b0);
    check("t4_ren0", 32'(o_ren0), 32'd1);
    check("t4_rdt0", 32'(o_rdt0), 32'h11);
    check("t4_rid0", 32'(o_rid0), 32'd1);
    set_p1(0, 0, '0, '0, '0);
    step(1'b0);
    check("t4_ren1", 32'(o_ren1), 32'd1);
    check("t4_rdt1", 32'(o_rdt1), 32'h22);
    check("t4_rid1", 32'(o_rid1), 32'd2);

    // Reset mid-read: granted p1 read during rst yields no return.
    set_p1(1, 0, 13'h0011, 6'd7, '0);
    step(1'b1);
    set_p1(0, 0, '0, '0, '0);
    step(1'b0);
    check("t5_ren1", 32'(o_ren1), 32'd0);
    check("t5_rid1", 32'(o_rid1), 32'd0);
    // Counter cleared: port 1 again waits exactly STV denials.
    set_p0(1, 1, 13'h0300, '0, 8'h03);
    set_p1(1, 1, 13'h0301, '0, 8'h04);
    for (int k = 0; k <= STV; k++) begin
      step(1'b0);
      check("t5_p1ack", 32'(g1), 32'(k == STV));
    end
    set_p0(0, 0, '0, '0, '0);
    set_p1(0, 0, '0, '0, '0);
    step(1'b0);

    // Random traffic: each master holds its request until acked.
    for (int c = 0; c < 3000; c++) begin
      if (!p0_req || g0) begin
        if ($urandom_range(0, 99) < 60)
          set_p0(1, 1'($urandom_range(0, 1)), DAW'($urandom_range(0, 15)),
                 IDW'($urandom), 8'($urandom));
        else
          set_p0(0, 0, '0, '0, '0);
      end
      if (!p1_req || g1) begin
        if ($urandom_range(0, 99) < 60)
          set_p1(1, 1'($urandom_range(0, 1)), DAW'($urandom_range(0, 15)),
                 IDW'($urandom), 8'($urandom));
        else
          set_p1(0, 0, '0, '0, '0);
      end
      step(1'($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
